frog_checker: RTL and testbench

FROG_CHECKER -- requirements
Module: frog_checker

---
 rtl/frog_checker.sv | 123 ++++++++++++
 tb/tb_frog_checker.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/frog_checker.sv
// Self-synchronising checker for a serial LFSR ("frog") stream with programmable taps.
// Optional bit counter enabled by defining FROG_CHECKER_BITCNT_EN.
module frog_checker #(
  parameter int N        = 16,
  parameter int ERR_W    = 16,
  parameter int LOSS_THR = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  // "program" is a reserved word in SystemVerilog, hence the shorter name
  input  logic             prog,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      bit_count,
  output logic [N-1:0]     window_test,
  output logic [N-1:0]     taps_test
);

  localparam int FILL_W = $clog2(N + 1);
  localparam int RUN_W  = $clog2(LOSS_THR + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SYNC, CHECK} state_t;

  state_t             state;
  logic [N-1:0]       taps;
  logic [N-1:0]       w;
  logic [FILL_W-1:0]  fill;
  logic [RUN_W-1:0]   run;
  logic               expect_bit;
  logic               mismatch;
  logic               check_bit;

  assign expect_bit  = ^(w & taps);
  assign mismatch    = din ^ expect_bit;
  assign check_bit   = (state == CHECK) && din_valid && !load;
  assign window_test = w;
  assign taps_test   = taps;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      taps      <= '0;
      w         <= '0;
      fill      <= '0;
      run       <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= 1'b0;
      if (load) begin
        state  <= LOAD;
        locked <= 1'b0;
        taps   <= {prog, taps[N-1:1]};
        w      <= '0;
        fill   <= '0;
        run    <= '0;
      end else begin
        if (clr)
          err_count <= '0;
        case (state)
          LOAD: begin
            state  <= SYNC;
            locked <= 1'b0;
          end
          SYNC: begin
            if (din_valid) begin
              w    <= {din, w[N-1:1]};
              fill <= fill + 1'b1;
              if (fill == FILL_W'(N - 1)) begin
                state  <= CHECK;
                locked <= 1'b1;
              end
            end
          end
          CHECK: begin
            if (din_valid) begin
              // Reference keeps running on its own prediction so a flipped bit is counted once
              w   <= {expect_bit, w[N-1:1]};
              err <= mismatch;
              if (mismatch) begin
                if (!clr && err_count != {ERR_W{1'b1}})
                  err_count <= err_count + 1'b1;
                if (run == RUN_W'(LOSS_THR - 1)) begin
                  state  <= SYNC;
                  locked <= 1'b0;
                  run    <= '0;
                  fill   <= '0;
                end else begin
                  run <= run + 1'b1;
                end
              end else begin
                run <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef FROG_CHECKER_BITCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bit_count <= '0;
    else if (!load) begin
      if (clr)
        bit_count <= '0;
      else if (check_bit && bit_count != 32'hFFFF_FFFF)
        bit_count <= bit_count + 32'd1;
    end
  end
`else
  assign bit_count = '0;
`endif

endmodule

// File: tb/tb_frog_checker.sv
// Directed bench for frog_checker: taps load, lock, single flip, lock loss, saturation, gaps, clear, reset.
module tb_frog_checker;
  localparam int N        = 16;
  localparam int ERR_W    = 4;
  localparam int LOSS_THR = 4;
  localparam logic [15:0] TAPS = 16'hB400;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef FROG_CHECKER_BITCNT_EN
  localparam bit BC_ON = 1'b1;
`else
  localparam bit BC_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load = 1'b0;
  logic             prog = 1'b0;
  logic             din = 1'b0;
  logic             din_valid = 1'b0;
  logic             clr = 1'b0;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_count;
  logic [31:0]      bit_count;
  logic [N-1:0]     window_test;
  logic [N-1:0]     taps_test;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit dropped = 1'b0;
  logic [15:0] g;
  logic [15:0] w_hold;

  frog_checker #(.N(N), .ERR_W(ERR_W), .LOSS_THR(LOSS_THR)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .prog(prog), .din(din),
    .din_valid(din_valid), .clr(clr), .locked(locked), .err(err),
    .err_count(err_count), .bit_count(bit_count),
    .window_test(window_test), .taps_test(taps_test)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit l, input bit p, input bit d, input bit v, input bit c);
    load = l; prog = p; din = d; din_valid = v; clr = c;
    @(posedge clk);
    #1;
    if (err === 1'b1) pulses++;
    if (locked !== 1'b1) dropped = 1'b1;
  endtask

  // One stream bit from the reference generator, optionally inverted
  task automatic send(input bit flip, input bit v, input bit c);
    tick(1'b0, 1'b0, g[0] ^ flip, v, c);
    if (v) g = {^(g & TAPS), g[15:1]};
  endtask

  initial begin
    @(posedge clk); @(posedge clk); #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_taps", 32'(taps_test), 32'd0);
    check("rst_window", 32'(window_test), 32'd0);
    check("rst_bit_count", bit_count, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("idle_window", 32'(window_test), 32'd0);
    check("idle_locked", 32'(locked), 32'd0);

    for (int i = 0; i < 16; i++) tick(1'b1, TAPS[i], 1'b1, 1'b1, 1'b0);
    check("load_taps", 32'(taps_test), 32'hB400);
    check("load_window", 32'(window_test), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sync_locked", 32'(locked), 32'd0);

    g = SEED;
    pulses = 0;
    for (int i = 0; i < 15; i++) send(1'b0, 1'b1, 1'b0);
    check("lock_before_16", 32'(locked), 32'd0);
    send(1'b0, 1'b1, 1'b0);
    check("lock_at_16", 32'(locked), 32'd1);
    check("lock_window_seed", 32'(window_test), 32'hACE1);
    for (int i = 0; i < 1000; i++) send(1'b0, 1'b1, 1'b0);
    check("clean_pulses", 32'(pulses), 32'd0);
    check("clean_err_count", 32'(err_count), 32'd0);
    check("clean_bit_count", bit_count, BC_ON ? 32'd1000 : 32'd0);

    pulses = 0; dropped = 1'b0;
    for (int i = 0; i < 99; i++) send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    check("flip_err", 32'(err), 32'd1);
    for (int i = 0; i < 20; i++) send(1'b0, 1'b1, 1'b0);
    check("flip_pulses", 32'(pulses), 32'd1);
    check("flip_err_count", 32'(err_count), 32'd1);
    check("flip_no_drop", 32'(dropped), 32'd0);

    for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 1'b0);
    check("loss_held_3", 32'(locked), 32'd1);
    send(1'b1, 1'b1, 1'b0);
    check("loss_locked", 32'(locked), 32'd0);
    check("loss_err", 32'(err), 32'd1);
    check("loss_err_count", 32'(err_count), 32'd5);
    for (int i = 0; i < 15; i++) send(1'b0, 1'b1, 1'b0);
    check("relock_15", 32'(locked), 32'd0);
    send(1'b0, 1'b1, 1'b0);
    check("relock_16", 32'(locked), 32'd1);
    pulses = 0;
    for (int i = 0; i < 50; i++) send(1'b0, 1'b1, 1'b0);
    check("relock_pulses", 32'(pulses), 32'd0);
    check("relock_err_count", 32'(err_count), 32'd5);
    check("relock_bit_count", bit_count, BC_ON ? 32'd1174 : 32'd0);

    send(1'b0, 1'b0, 1'b1);
    check("clr_err_count", 32'(err_count), 32'd0);
    check("clr_bit_count", bit_count, 32'd0);
    pulses = 0; dropped = 1'b0;
    for (int i = 1; i <= 60; i++) send((i % 3) == 0, 1'b1, 1'b0);
    check("sat_err_count", 32'(err_count), 32'd15);
    check("sat_pulses", 32'(pulses), 32'd20);
    check("sat_no_drop", 32'(dropped), 32'd0);

    send(1'b0, 1'b0, 1'b1);
    pulses = 0; dropped = 1'b0;
    for (int i = 0; i < 200; i++) send(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    check("gap_pulses", 32'(pulses), 32'd0);
    check("gap_err_count", 32'(err_count), 32'd0);
    check("gap_no_drop", 32'(dropped), 32'd0);
    w_hold = window_test;
    send(1'b1, 1'b0, 1'b0);
    check("idle_bit_window", 32'(window_test), 32'(w_hold));
    check("idle_bit_err", 32'(err), 32'd0);

    send(1'b1, 1'b1, 1'b0);
    check("pre_clr_err_count", 32'(err_count), 32'd1);
    send(1'b1, 1'b1, 1'b1);
    check("clr_mm_err", 32'(err), 32'd1);
    check("clr_mm_err_count", 32'(err_count), 32'd0);
    send(1'b0, 1'b1, 1'b0);
    check("post_clr_err", 32'(err), 32'd0);
    check("post_clr_err_count", 32'(err_count), 32'd0);
    check("post_clr_locked", 32'(locked), 32'd1);
    check("post_clr_bit_count", bit_count, BC_ON ? 32'd1 : 32'd0);

    send(1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_locked", 32'(locked), 32'd0);
    check("async_rst_err_count", 32'(err_count), 32'd0);
    check("async_rst_taps", 32'(taps_test), 32'd0);
    check("async_rst_window", 32'(window_test), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
